// File: rtl/miner_job_master.sv
// Bus master that loads one mining job into the miner slave port, polls for a nonce and returns it.
// Optional poll timeout: define MINER_POLL_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module miner_job_master #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         jobValid,
    output logic         jobReady,
    input  logic         jobLoadTarget,
    input  logic [255:0] jobTarget,
    input  logic [607:0] jobMessage,
    output logic [4:0]   masterAddr,
    output logic [31:0]  masterWriteData,
    output logic         masterWrite,
    output logic         masterRead,
    output logic         masterChipSelect,
    input  logic [31:0]  masterReadData,
    output logic         resultValid,
    output logic [31:0]  resultNonce,
    output logic         resultTimeout
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_TGT_WR,
        S_TGT_GO,
        S_TGT_CLR,
        S_MSG_WR,
        S_MSG_GO,
        S_MSG_CLR,
        S_GAP,
        S_POLL_A,
        S_POLL_D,
        S_NONCE_A,
        S_NONCE_D,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [255:0]   tgt_q, tgt_d;
    logic [607:0]   msg_q, msg_d;
    logic [31:0]    nonce_q, nonce_d;
    logic           ready_q, ready_d;
    logic [4:0]     addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           wr_q, wr_d;
    logic           rd_q, rd_d;
    logic           cs_q, cs_d;
    logic           valid_q, valid_d;

`ifdef MINER_POLL_TIMEOUT_EN
    logic [31:0]    tcnt_q, tcnt_d;
    logic           tmo_q, tmo_d;
`else
    logic           unused_tmo;
    assign unused_tmo = |TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        msg_d   = msg_q;
        nonce_d = nonce_q;

        unique case (state_q)
            S_IDLE: begin
                if (jobValid && ready_q) begin
                    tgt_d   = jobTarget;
                    msg_d   = jobMessage;
                    cnt_d   = '0;
                    state_d = jobLoadTarget ? S_TGT_WR : S_MSG_WR;
                end
            end
            // Job words are shifted out MSW first so the bus data is always the top word
            S_TGT_WR: begin
                tgt_d = tgt_q << 32;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd7) state_d = S_TGT_GO;
            end
            S_TGT_GO:  state_d = S_TGT_CLR;
            S_TGT_CLR: begin
                cnt_d   = '0;
                state_d = S_MSG_WR;
            end
            S_MSG_WR: begin
                msg_d = msg_q << 32;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd18) state_d = S_MSG_GO;
            end
            S_MSG_GO:  state_d = S_MSG_CLR;
            S_MSG_CLR: state_d = S_GAP;
            S_GAP:     state_d = S_POLL_A;
            S_POLL_A:  state_d = S_POLL_D;
            S_POLL_D: begin
                state_d = (masterReadData == 32'd3) ? S_NONCE_A : S_POLL_A;
            end
            S_NONCE_A: state_d = S_NONCE_D;
            S_NONCE_D: begin
                nonce_d = masterReadData;
                state_d = S_DONE;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

`ifdef MINER_POLL_TIMEOUT_EN
        tcnt_d = tcnt_q;
        tmo_d  = 1'b0;
        if (state_d == S_GAP) tcnt_d = '0;
        if (state_q == S_POLL_A || state_q == S_POLL_D) begin
            tcnt_d = tcnt_q + 32'd1;
            // A found nonce on the final poll still wins over the timeout
            if (tcnt_d >= 32'(TIMEOUT_CYCLES) && state_d != S_NONCE_A) begin
                state_d = S_DONE;
                tmo_d   = 1'b1;
            end
        end
`endif

        addr_d  = '0;
        wdata_d = '0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        case (state_d)
            S_TGT_WR: begin
                wr_d    = 1'b1;
                addr_d  = 5'd9 - cnt_d;
                wdata_d = tgt_d[255:224];
            end
            S_TGT_GO: begin
                wr_d    = 1'b1;
                addr_d  = 5'd1;
                wdata_d = 32'd1;
            end
            S_TGT_CLR, S_MSG_CLR: begin
                wr_d    = 1'b1;
                addr_d  = 5'd1;
            end
            S_MSG_WR: begin
                wr_d    = 1'b1;
                addr_d  = 5'd29 - cnt_d;
                wdata_d = msg_d[607:576];
            end
            S_MSG_GO: begin
                wr_d    = 1'b1;
                addr_d  = 5'd1;
                wdata_d = 32'd2;
            end
            S_POLL_A, S_POLL_D: begin
                rd_d    = 1'b1;
            end
            S_NONCE_A, S_NONCE_D: begin
                rd_d    = 1'b1;
                addr_d  = 5'd10;
            end
            default: ;
        endcase

        cs_d    = wr_d | rd_d;
        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            msg_q   <= '0;
            nonce_q <= '0;
            ready_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            cs_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            msg_q   <= msg_d;
            nonce_q <= nonce_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cs_q    <= cs_d;
            valid_q <= valid_d;
        end
    end

`ifdef MINER_POLL_TIMEOUT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= tmo_d;
        end
    end

    assign resultTimeout = tmo_q;
`else
    assign resultTimeout = 1'b0;
`endif

    assign jobReady         = ready_q;
    assign masterAddr       = addr_q;
    assign masterWriteData  = wdata_q;
    assign masterWrite      = wr_q;
    assign masterRead       = rd_q;
    assign masterChipSelect = cs_q;
    assign resultValid      = valid_q;
    assign resultNonce      = nonce_q;

endmodule
